// File: rtl/buffer_sched_pkg.sv
// Shared definitions for the buffer round-robin scheduler: FSM state codes and default widths.
package buffer_sched_pkg;

  localparam int N_DEF  = 32;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RSVD  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after Ptr (mod R) wins.
module rr_arbiter #(
  parameter int R  = 4,
  parameter int RW = 2
) (
  input  logic [R-1:0]  Req,
  input  logic [RW-1:0] Ptr,
  output logic [R-1:0]  Gnt,
  output logic [RW-1:0] GntIdx,
  output logic          Any
);

  logic [RW-1:0] idx;

  // R is a power of two, so the RW-bit add wraps modulo R for free
  always_comb begin
    Gnt    = '0;
    GntIdx = '0;
    Any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < R; k++) begin
      idx = Ptr + RW'(k);
      if (!Any && Req[idx]) begin
        Any      = 1'b1;
        Gnt[idx] = 1'b1;
        GntIdx   = idx;
      end
    end
  end

endmodule

// File: rtl/buffer_rr_scheduler.sv
// Shares one Buffer FIFO between R producers and one consumer; sequences idle, run and flush.
module buffer_rr_scheduler
  import buffer_sched_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int R  = 4,
  parameter int RW = 2,
  parameter int CW = CW_DEF
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Pwr_off,
  input  logic           En,
  input  logic           Flush,
  input  logic [R-1:0]   ReqVal,
  input  logic [R*N-1:0] ReqData,
  output logic [R-1:0]   ReqGnt,
  output logic           BufPushEn,
  output logic [N-1:0]   BufPushVal,
  output logic           BufPullEn,
  input  logic           BufIsFull,
  input  logic           BufIsEmpty,
  input  logic           PopReq,
  output logic           PopAck,
  output logic [1:0]     State,
  output logic           FlushDone,
  output logic [CW-1:0]  PushCount
);

  sched_state_e  state_q, state_d;
  logic [RW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_done_q, flush_done_d;

  logic          rst_all;
  logic          is_run, is_flush;
  logic [R-1:0]  req_masked;
  logic [R-1:0]  gnt;
  logic [RW-1:0] gnt_idx;
  logic          any_gnt;

  assign rst_all  = Rst | Pwr_off;
  assign is_run   = (state_q == ST_RUN);
  assign is_flush = (state_q == ST_FLUSH);

  // Pushes are refused on full even if a pop frees a slot this cycle
  assign req_masked = (is_run && !BufIsFull) ? ReqVal : '0;

  rr_arbiter #(.R(R), .RW(RW)) u_arb (
    .Req    (req_masked),
    .Ptr    (ptr_q),
    .Gnt    (gnt),
    .GntIdx (gnt_idx),
    .Any    (any_gnt)
  );

  assign ReqGnt     = gnt;
  assign BufPushEn  = any_gnt;
  assign BufPushVal = any_gnt ? ReqData[int'(gnt_idx)*N +: N] : '0;
  assign PopAck     = is_run & PopReq & ~BufIsEmpty;
  assign BufPullEn  = PopAck | (is_flush & ~BufIsEmpty);
  assign State      = state_q;
  assign FlushDone  = flush_done_q;
  assign PushCount  = cnt_q;

  always_comb begin
    state_d      = ST_IDLE;
    flush_done_d = 1'b0;
    ptr_d        = any_gnt ? gnt_idx + RW'(1) : ptr_q;
    cnt_d        = any_gnt ? cnt_q + CW'(1) : cnt_q;
    case (state_q)
      ST_IDLE:  state_d = En ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (Flush)    state_d = ST_FLUSH;
        else if (!En) state_d = ST_IDLE;
        else          state_d = ST_RUN;
      end
      ST_FLUSH: begin
        state_d      = BufIsEmpty ? ST_IDLE : ST_FLUSH;
        flush_done_d = BufIsEmpty;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (rst_all) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_buffer_rr_scheduler.sv
// Directed bench for buffer_rr_scheduler: vector table plus reset and counter-wrap sequences.
module tb_buffer_rr_scheduler;

  localparam int N  = 32;
  localparam int R  = 4;
  localparam int RW = 2;
  localparam int CW = 16;

  localparam logic [31:0] D0 = 32'hDDDD_0000;
  localparam logic [31:0] D1 = 32'hDDDD_0001;
  localparam logic [31:0] D2 = 32'hDDDD_0002;
  localparam logic [31:0] D3 = 32'hDDDD_0003;

  logic           clk = 1'b0;
  logic           rst, pwr_off, en, flush;
  logic [R-1:0]   req_val;
  logic [R*N-1:0] req_data;
  logic [R-1:0]   req_gnt;
  logic           push_en, pull_en, is_full, is_empty, pop_req, pop_ack, flush_done;
  logic [N-1:0]   push_val;
  logic [1:0]     state;
  logic [CW-1:0]  push_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buffer_rr_scheduler #(.N(N), .R(R), .RW(RW), .CW(CW)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .Pwr_off    (pwr_off),
    .En         (en),
    .Flush      (flush),
    .ReqVal     (req_val),
    .ReqData    (req_data),
    .ReqGnt     (req_gnt),
    .BufPushEn  (push_en),
    .BufPushVal (push_val),
    .BufPullEn  (pull_en),
    .BufIsFull  (is_full),
    .BufIsEmpty (is_empty),
    .PopReq     (pop_req),
    .PopAck     (pop_ack),
    .State      (state),
    .FlushDone  (flush_done),
    .PushCount  (push_count)
  );

  typedef struct {
    logic        en, fl;
    logic [3:0]  req;
    logic        full, emp, pop;
    logic [3:0]  gnt;
    logic        push;
    logic [31:0] val;
    logic        pull, ack;
    logic [1:0]  st;
    logic        fd;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] g, input logic p,
                             input logic [31:0] v, input logic pl, input logic a,
                             input logic [1:0] s, input logic f, input logic [15:0] c);
    chk({tag, ".gnt"},   32'(req_gnt),    32'(g));
    chk({tag, ".push"},  32'(push_en),    32'(p));
    chk({tag, ".val"},   push_val,        v);
    chk({tag, ".pull"},  32'(pull_en),    32'(pl));
    chk({tag, ".ack"},   32'(pop_ack),    32'(a));
    chk({tag, ".state"}, 32'(state),      32'(s));
    chk({tag, ".fd"},    32'(flush_done), 32'(f));
    chk({tag, ".cnt"},   32'(push_count), 32'(c));
  endtask

  // Walks into FLUSH, then resets via Rst or Pwr_off on a cycle where the flush would complete
  task automatic reset_mid_flush(input bit use_pwr, input string tag);
    en = 1'b1; flush = 1'b0; req_val = 4'b0000; is_full = 1'b0; is_empty = 1'b1; pop_req = 1'b0;
    tick();
    req_val = 4'b0100;
    tick();
    req_val = 4'b0000; flush = 1'b1; is_empty = 1'b0;
    tick();
    flush = 1'b0; req_val = 4'b1111; is_empty = 1'b1; pop_req = 1'b1; en = 1'b0;
    #2;
    chk({tag, ".inflush"}, 32'(state), 32'(2));
    if (use_pwr) pwr_off = 1'b1; else rst = 1'b1;
    tick();
    rst = 1'b0; pwr_off = 1'b0; is_empty = 1'b0;
    #2;
    chk_outputs({tag, ".after"}, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0);
    en = 1'b1;
    tick();
    #2;
    chk({tag, ".ptr0gnt"}, 32'(req_gnt), 32'(4'b0001));
    chk({tag, ".ptr0val"}, push_val, D0);
    tick();
    #2;
    chk({tag, ".cnt1"}, 32'(push_count), 32'(1));
    req_val = 4'b0000;
  endtask

  initial begin
    req_data = {D3, D2, D1, D0};
    rst = 1'b1; pwr_off = 1'b0; en = 1'b0; flush = 1'b0;
    req_val = 4'b1111; is_full = 1'b0; is_empty = 1'b0; pop_req = 1'b1;

    //            en fl req    fu em po  gnt    pu val    pl ac st fd cnt
    vecs.push_back('{1,0,4'hF, 0,1,0, 4'h0,  0,32'h0, 0,0,0,0,16'd0});
    vecs.push_back('{1,0,4'hF, 0,1,0, 4'h1,  1,D0,    0,0,1,0,16'd0});
    vecs.push_back('{1,0,4'hF, 0,1,0, 4'h2,  1,D1,    0,0,1,0,16'd1});
    vecs.push_back('{1,0,4'hF, 0,1,0, 4'h4,  1,D2,    0,0,1,0,16'd2});
    vecs.push_back('{1,0,4'hF, 0,1,0, 4'h8,  1,D3,    0,0,1,0,16'd3});
    vecs.push_back('{1,0,4'hF, 0,1,0, 4'h1,  1,D0,    0,0,1,0,16'd4});
    vecs.push_back('{1,0,4'h0, 0,1,0, 4'h0,  0,32'h0, 0,0,1,0,16'd5});
    vecs.push_back('{1,0,4'h2, 0,1,0, 4'h2,  1,D1,    0,0,1,0,16'd5});
    vecs.push_back('{1,0,4'h3, 0,1,0, 4'h1,  1,D0,    0,0,1,0,16'd6});
    vecs.push_back('{1,0,4'h3, 0,1,0, 4'h2,  1,D1,    0,0,1,0,16'd7});
    vecs.push_back('{1,0,4'h0, 0,1,0, 4'h0,  0,32'h0, 0,0,1,0,16'd8});
    vecs.push_back('{1,0,4'h3, 0,1,0, 4'h1,  1,D0,    0,0,1,0,16'd8});
    vecs.push_back('{1,0,4'h4, 1,0,1, 4'h0,  0,32'h0, 1,1,1,0,16'd9});
    vecs.push_back('{1,0,4'h4, 0,0,1, 4'h4,  1,D2,    1,1,1,0,16'd9});
    vecs.push_back('{1,0,4'h0, 0,1,1, 4'h0,  0,32'h0, 0,0,1,0,16'd10});
    vecs.push_back('{1,0,4'h0, 0,0,1, 4'h0,  0,32'h0, 1,1,1,0,16'd10});
    vecs.push_back('{1,1,4'hF, 0,0,0, 4'h8,  1,D3,    0,0,1,0,16'd10});
    vecs.push_back('{1,0,4'hF, 0,0,0, 4'h0,  0,32'h0, 1,0,2,0,16'd11});
    vecs.push_back('{1,0,4'hF, 0,0,1, 4'h0,  0,32'h0, 1,0,2,0,16'd11});
    vecs.push_back('{1,0,4'hF, 0,0,0, 4'h0,  0,32'h0, 1,0,2,0,16'd11});
    vecs.push_back('{0,0,4'hF, 0,1,0, 4'h0,  0,32'h0, 0,0,2,0,16'd11});
    vecs.push_back('{0,0,4'hF, 0,1,1, 4'h0,  0,32'h0, 0,0,0,1,16'd11});
    vecs.push_back('{0,0,4'hF, 0,1,1, 4'h0,  0,32'h0, 0,0,0,0,16'd11});
    vecs.push_back('{1,0,4'h0, 0,1,0, 4'h0,  0,32'h0, 0,0,0,0,16'd11});
    vecs.push_back('{0,0,4'h1, 0,1,0, 4'h1,  1,D0,    0,0,1,0,16'd11});
    vecs.push_back('{0,0,4'hF, 0,0,1, 4'h0,  0,32'h0, 0,0,0,0,16'd12});
    vecs.push_back('{1,0,4'h0, 0,1,0, 4'h0,  0,32'h0, 0,0,0,0,16'd12});
    vecs.push_back('{0,1,4'h0, 0,1,0, 4'h0,  0,32'h0, 0,0,1,0,16'd12});
    vecs.push_back('{0,0,4'h0, 0,1,0, 4'h0,  0,32'h0, 0,0,2,0,16'd12});
    vecs.push_back('{0,0,4'hF, 0,0,1, 4'h0,  0,32'h0, 0,0,0,1,16'd12});

    tick();
    tick();
    rst = 1'b0;
    #2;
    chk_outputs("reset", 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; flush = vecs[i].fl; req_val = vecs[i].req;
      is_full = vecs[i].full; is_empty = vecs[i].emp; pop_req = vecs[i].pop;
      #2;
      chk_outputs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].push, vecs[i].val,
                  vecs[i].pull, vecs[i].ack, vecs[i].st, vecs[i].fd, vecs[i].cnt);
      tick();
    end

    reset_mid_flush(1'b0, "rst_flush");
    reset_mid_flush(1'b1, "pwr_flush");

    // 0x10000 consecutive pushes from a fresh reset bring PushCount back to 0
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; flush = 1'b0; req_val = 4'b0001;
    is_full = 1'b0; is_empty = 1'b1; pop_req = 1'b0;
    tick();
    repeat (65535) tick();
    #2;
    chk("wrap.ffff", 32'(push_count), 32'h0000_FFFF);
    chk("wrap.gnt", 32'(req_gnt), 32'(4'b0001));
    tick();
    #2;
    chk("wrap.zero", 32'(push_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_rr_scheduler.md
Name: buffer_rr_scheduler

Overview:
Shares one Buffer FIFO (depth M, width N) between R producers and one consumer.
- Producer side: round-robin arbitration selects at most one producer per cycle and drives the Buffer push interface.
- Consumer side: gates pop requests against Buffer empty status.
- A small FSM sequences enable, normal run and flush (drain to empty). The block sits directly beside the Buffer instance and is the only driver of its PushEn/PullEn/PushVal.

Parameters:
N, 32, data width; equals the Buffer N
R, 4, number of producers; power of 2, at least 2
RW, 2, log2(R); width of the round-robin pointer
CW, 16, width of the push statistics counter

Ports:
Clk  in  1  system clock; all state updates on the rising edge
Rst  in  1  synchronous, active-high reset
Pwr_off  in  1  power-off; while high, behaves exactly as Rst
En  in  1  scheduler enable
Flush  in  1  drain request; sampled only in RUN
ReqVal  in  R  per-producer push request
ReqData  in  R*N  producer data; producer i occupies bits [i*N +: N]
ReqGnt  out  R  one-hot grant; the data of the granted producer is pushed this cycle
BufPushEn  out  1  to Buffer PushEn
BufPushVal  out  N  to Buffer PushVal
BufPullEn  out  1  to Buffer PullEn
BufIsFull  in  1  from Buffer IsFull
BufIsEmpty  in  1  from Buffer IsEmpty
PopReq  in  1  consumer pop request
PopAck  out  1  pop accepted this cycle; consumer takes the Buffer PullVal
State  out  2  current FSM state code
FlushDone  out  1  single-cycle pulse on FLUSH exit
PushCount  out  CW  total accepted pushes; wraps modulo 2^CW

Behaviour:
- Reset (Rst or Pwr_off high at the edge):
  - State = IDLE, Ptr = 0, PushCount = 0, FlushDone = 0.
  - All combinational outputs are 0 while State = IDLE.
  - Reset mid-flush or mid-run abandons the operation. Buffer contents are not touched by this block; the Buffer has its own Rst.
- FSM states:
  - IDLE: code 0. No grants, no pops. IDLE -> RUN when En = 1.
  - RUN: code 1.
    - RUN -> FLUSH when Flush = 1; this has priority over En = 0.
    - RUN -> IDLE when En = 0 and Flush = 0.
  - FLUSH: code 2. Grants suppressed, PopReq ignored.
    - BufPullEn = ~BufIsEmpty every cycle.
    - FLUSH -> IDLE when BufIsEmpty = 1; FlushDone = 1 for the first cycle in IDLE.
    - En is ignored during FLUSH.
  - Code 3 is unused; treat as IDLE and go to IDLE on the next edge.
- Arbitration (RUN only, combinational, zero latency):
  - Candidate set: ReqVal, masked to 0 when BufIsFull = 1.
  - Search order: Ptr, Ptr+1, ..., Ptr+R-1, all modulo R. The first set bit wins.
  - ReqGnt = one-hot of the winner; BufPushEn = |ReqGnt.
  - BufPushVal = ReqData slice of the winner; 0 when there is no grant.
  - When BufPushEn = 1: next Ptr = (winner + 1) mod R, and PushCount increments by 1 (wraps 2^CW-1 -> 0).
  - No grant: Ptr holds.
- Full boundary:
  - No push while BufIsFull = 1, even if a pop occurs in the same cycle (conservative).
- Pop (RUN only):
  - BufPullEn = PopAck = PopReq & ~BufIsEmpty.
  - A pop on empty is never issued. PopReq simply waits; no error is flagged.
- Simultaneous push and pop in RUN are both allowed when neither full nor empty.
- Producer protocol: a producer holds ReqVal and ReqData until it sees ReqGnt. The block keeps no request storage.
- Outputs are combinational from registered state plus inputs. There is no combinational path from BufPushVal back into any input.

Decomposition:
- Shared package (buffer_sched_pkg):
  - State encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2.
  - Default widths N and CW.
- Sub-module rr_arbiter (parameters R, RW):
  - Inputs: Req[R], Ptr[RW].
  - Outputs: Gnt[R] one-hot, GntIdx[RW], Any.
  - Purely combinational; reusable for other shared resources.
- The top level holds the FSM, Ptr, PushCount, the data mux and the Buffer-side gating.

Test Plan:
1. Reset then En = 1, ReqVal = 4'b1111, ReqData = {D3, D2, D1, D0}, buffer never full.
   -> Grants cycle 0001, 0010, 0100, 1000, 0001 on consecutive cycles; BufPushVal follows D0..D3; PushCount = 5 after 5 cycles.
2. Ptr = 2, ReqVal = 4'b0011.
   -> Grant 0001, then Ptr = 1 and the next grant is 0010; an idle cycle (ReqVal = 0) leaves Ptr at 2.
3. BufIsFull = 1 with ReqVal = 4'b0100 and PopReq = 1.
   -> ReqGnt = 0 and BufPushEn = 0; BufPullEn = PopAck = 1. When BufIsFull drops, the grant to 0100 is issued that cycle.
4. BufIsEmpty = 1, PopReq = 1 in RUN.
   -> PopAck = 0 and BufPullEn = 0. When BufIsEmpty goes 0, PopAck = 1 in the same cycle.
5. RUN with 3 entries, Flush = 1, ReqVal = 4'b1111.
   -> State = FLUSH; BufPullEn = 1 for 3 cycles with no grants; BufIsEmpty = 1 then State = IDLE and FlushDone pulses exactly 1 cycle.
6. Rst = 1 (then, separately, Pwr_off = 1) mid-FLUSH with PushCount = 0xFFFF.
   -> Next cycle: State = IDLE, PushCount = 0, Ptr = 0, all outputs 0, no FlushDone pulse. A separate run of 0x10000 pushes shows PushCount wrapping to 0.
